// File: rtl/signed_addsub_pipe.sv
// Two-stage signed add/subtract pipeline with valid/ready handshakes, optional saturation,
// a feedback accumulator and a saturating overflow event counter.
module signed_addsub_pipe #(
   parameter int unsigned N    = 8,
   parameter int unsigned CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   input  logic [1:0]      sign,
   input  logic            sat,
   input  logic            acc_en,
   input  logic            acc_clr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    res,
   output logic            ovf,
   output logic [N-1:0]    acc,
   output logic [CNTW-1:0] ovf_cnt
);

   logic         s1_valid_q;
   logic [N-1:0] s1_a_q;
   logic [N-1:0] s1_b_q;
   logic [1:0]   s1_sign_q;
   logic         s1_sat_q;
   logic         s1_acc_en_q;
   logic         s1_acc_clr_q;

   logic           s2_load;
   logic           in_fire;
   logic [N-1:0]   a_sel;
   logic [N+1:0]   op_a;
   logic [N+1:0]   op_b;
   logic [N+1:0]   sum;
   logic           sum_ovf;
   logic [N-1:0]   sum_res;

   assign in_ready = !s1_valid_q || !out_valid || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign s2_load  = s1_valid_q && (!out_valid || out_ready);

   // Two guard bits keep -(-2^(N-1)) and the worst-case sum exact.
   always_comb begin
      a_sel = s1_acc_en_q ? (s1_acc_clr_q ? '0 : acc) : s1_a_q;
      op_a  = {{2{a_sel[N-1]}}, a_sel};
      op_b  = {{2{s1_b_q[N-1]}}, s1_b_q};
      if (s1_sign_q[1]) op_a = -op_a;
      if (s1_sign_q[0]) op_b = -op_b;
      sum     = op_a + op_b;
      sum_ovf = !((sum[N+1:N-1] == 3'b000) || (sum[N+1:N-1] == 3'b111));
      sum_res = sum[N-1:0];
      if (sum_ovf && s1_sat_q) begin
         sum_res = sum[N+1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_sign_q    <= '0;
         s1_sat_q     <= 1'b0;
         s1_acc_en_q  <= 1'b0;
         s1_acc_clr_q <= 1'b0;
         out_valid    <= 1'b0;
         res          <= '0;
         ovf          <= 1'b0;
         acc          <= '0;
         ovf_cnt      <= '0;
      end else begin
         if (in_fire) begin
            s1_valid_q   <= 1'b1;
            s1_a_q       <= a;
            s1_b_q       <= b;
            s1_sign_q    <= sign;
            s1_sat_q     <= sat;
            s1_acc_en_q  <= acc_en;
            s1_acc_clr_q <= acc_clr;
         end else if (s2_load) begin
            s1_valid_q <= 1'b0;
         end

         if (s2_load) begin
            out_valid <= 1'b1;
            res       <= sum_res;
            ovf       <= sum_ovf;
            if (s1_acc_en_q) acc <= sum_res;
            if (sum_ovf && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CNTW'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
